// File: rtl/deskew_svm_sequencer.sv
// -----------------------------------------------------------------------------
// deskew_svm_sequencer
//
// Purpose:
//   Batch sequencer for the deskew + SVM classification pipeline. A rising edge
//   on the command level starts a batch of num_images_i images. For each image
//   the deskew block is started and waited on, then the SVM core is started
//   and waited on. A one-cycle interrupt marks the end of the batch. Every busy
//   state is guarded by a timeout that parks the FSM in ERROR until it is
//   cleared. An abort returns the FSM to IDLE without an interrupt.
//
// Handshake (start/ready):
//   A start output is a Moore level that is held for the whole start state.
//   The block acknowledges by dropping its ready (idle) input, which moves the
//   FSM to the matching WAIT state and releases the start. The block reports
//   completion by raising ready again. The two start outputs are never high
//   together.
//
// Ports:
//   clk             single clock, rising edge
//   reset           synchronous, active-low reset
//   cmd_start_i     command level; a 0->1 edge requests a batch (IDLE only)
//   num_images_i    batch size, sampled when the request is accepted
//   abort_i         abandon the batch in progress (busy states)
//   err_clr_i       leave ERROR
//   deskew_start_o  start to the deskew block
//   deskew_ready_i  deskew idle/done (high = idle)
//   svm_start_o     start to the SVM core
//   svm_ready_i     SVM idle/done (high = idle)
//   busy_o          batch in progress
//   done_intr_o     one-cycle batch-complete pulse
//   error_o         timeout error flag
//   images_done_o   images fully classified in the current or last batch
//   dbg_state_o     current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module deskew_svm_sequencer #(
  parameter int CNT_W = 8,
  parameter int TO_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_start_i,
  input  logic [CNT_W-1:0] num_images_i,
  input  logic             abort_i,
  input  logic             err_clr_i,
  output logic             deskew_start_o,
  input  logic             deskew_ready_i,
  output logic             svm_start_o,
  input  logic             svm_ready_i,
  output logic             busy_o,
  output logic             done_intr_o,
  output logic             error_o,
  output logic [CNT_W-1:0] images_done_o,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DSK_START = 3'd1,
    DSK_WAIT  = 3'd2,
    SVM_START = 3'd3,
    SVM_WAIT  = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  // Counter value one step before the all-ones limit: the edge that would
  // carry the counter onto the limit is the edge that forces ERROR.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t           r_state;
  state_t           w_next;
  logic             r_cmd_q;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_done_cnt;
  logic [TO_W-1:0]  r_to;

  logic             w_req;
  logic             w_busy_st;
  logic             w_timeout;
  logic [CNT_W-1:0] w_done_inc;
  logic             w_img_done;

  assign w_req      = cmd_start_i & ~r_cmd_q;
  assign w_busy_st  = (r_state == DSK_START) || (r_state == DSK_WAIT) ||
                      (r_state == SVM_START) || (r_state == SVM_WAIT);
  assign w_timeout  = w_busy_st && (r_to == TO_LAST);
  assign w_done_inc = r_done_cnt + 1'b1;
  // An image counts as classified only on the normal SVM_WAIT exit; abort and
  // timeout win over it and leave the count untouched.
  assign w_img_done = (r_state == SVM_WAIT) && svm_ready_i && !abort_i && !w_timeout;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_next = (num_images_i == '0) ? DONE : DSK_START;
        end
      end
      DSK_START: begin
        if (abort_i)              w_next = IDLE;
        else if (w_timeout)       w_next = ERROR;
        else if (!deskew_ready_i) w_next = DSK_WAIT;
      end
      DSK_WAIT: begin
        if (abort_i)             w_next = IDLE;
        else if (w_timeout)      w_next = ERROR;
        else if (deskew_ready_i) w_next = SVM_START;
      end
      SVM_START: begin
        if (abort_i)           w_next = IDLE;
        else if (w_timeout)    w_next = ERROR;
        else if (!svm_ready_i) w_next = SVM_WAIT;
      end
      SVM_WAIT: begin
        if (abort_i)          w_next = IDLE;
        else if (w_timeout)   w_next = ERROR;
        else if (svm_ready_i) w_next = (w_done_inc == r_num) ? DONE : DSK_START;
      end
      DONE:    w_next = IDLE;
      ERROR: begin
        if (err_clr_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: command edge register, batch size, image count, timeout
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cmd_q    <= 1'b0;
      r_num      <= '0;
      r_done_cnt <= '0;
      r_to       <= '0;
    end else begin
      r_cmd_q <= cmd_start_i;

      if ((r_state == IDLE) && w_req) begin
        r_num      <= num_images_i;
        r_done_cnt <= '0;
      end else if (w_img_done) begin
        r_done_cnt <= w_done_inc;
      end

      // Cleared on every state entry, so each busy state gets its own budget.
      if ((w_next != r_state) || !w_busy_st) begin
        r_to <= '0;
      end else begin
        r_to <= r_to + 1'b1;
      end
    end
  end

  // Output decode (Moore, from the state register only)
  always_comb begin
    deskew_start_o = 1'b0;
    svm_start_o    = 1'b0;
    busy_o         = 1'b0;
    done_intr_o    = 1'b0;
    error_o        = 1'b0;
    case (r_state)
      DSK_START: begin
        deskew_start_o = 1'b1;
        busy_o         = 1'b1;
      end
      DSK_WAIT:  busy_o = 1'b1;
      SVM_START: begin
        svm_start_o = 1'b1;
        busy_o      = 1'b1;
      end
      SVM_WAIT:  busy_o = 1'b1;
      DONE:      done_intr_o = 1'b1;
      ERROR:     error_o = 1'b1;
      default: ;
    endcase
  end

  assign images_done_o = r_done_cnt;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_deskew_svm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_deskew_svm_sequencer
//
// Directed bench for deskew_svm_sequencer (CNT_W=8, TO_W=4). Behavioural
// deskew and SVM models acknowledge a start after 2 cycles and finish 10
// cycles after the start was seen. A negedge monitor counts start edges,
// interrupt pulses and overlap/alternation violations, and records every
// change of images_done_o; the scoreboard compares those against exp_q.
// -----------------------------------------------------------------------------
module tb_deskew_svm_sequencer;

  localparam int CNT_W = 8;
  localparam int TO_W  = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ERROR = 3'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             cmd_start;
  logic [CNT_W-1:0] num_images;
  logic             abort;
  logic             err_clr;
  logic             dsk_start;
  logic             dsk_ready;
  logic             svm_start;
  logic             svm_ready;
  logic             busy;
  logic             done_intr;
  logic             error_f;
  logic [CNT_W-1:0] images_done;
  logic [2:0]       dbg_state;

  deskew_svm_sequencer #(.CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_start_i    (cmd_start),
    .num_images_i   (num_images),
    .abort_i        (abort),
    .err_clr_i      (err_clr),
    .deskew_start_o (dsk_start),
    .deskew_ready_i (dsk_ready),
    .svm_start_o    (svm_start),
    .svm_ready_i    (svm_ready),
    .busy_o         (busy),
    .done_intr_o    (done_intr),
    .error_o        (error_f),
    .images_done_o  (images_done),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- block models ----------------
  bit dsk_en   = 1'b1;
  bit svm_en   = 1'b1;
  int abort_at = -1;
  int svm_fin  = 0;

  initial begin
    dsk_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (dsk_en && dsk_start) begin
        repeat (2) @(negedge clk);
        dsk_ready = 1'b0;
        repeat (8) @(negedge clk);
        dsk_ready = 1'b1;
      end
    end
  end

  initial begin
    svm_ready = 1'b1;
    abort     = 1'b0;
    forever begin
      @(negedge clk);
      abort = 1'b0;
      if (svm_en && svm_start) begin
        repeat (2) @(negedge clk);
        svm_ready = 1'b0;
        repeat (8) @(negedge clk);
        svm_ready = 1'b1;
        svm_fin++;
        if (svm_fin == abort_at) abort = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  int n_done = 0, n_dsk_rise = 0, n_svm_rise = 0, n_dsk_hi = 0;
  int n_alt_err = 0, n_overlap = 0, last_kind = 0;
  logic p_dsk = 1'b0, p_svm = 1'b0;
  logic [CNT_W-1:0] p_img = '0;
  logic [CNT_W-1:0] obs_q[$];

  always @(negedge clk) begin
    if (done_intr) n_done++;
    if (dsk_start) n_dsk_hi++;
    if (dsk_start && svm_start) n_overlap++;
    if (dsk_start && !p_dsk) begin
      n_dsk_rise++;
      if (last_kind == 1) n_alt_err++;
      last_kind = 1;
    end
    if (svm_start && !p_svm) begin
      n_svm_rise++;
      if (last_kind != 1) n_alt_err++;
      last_kind = 2;
    end
    if (!busy) last_kind = 0;
    if (images_done != p_img) obs_q.push_back(images_done);
    p_dsk = dsk_start;
    p_svm = svm_start;
    p_img = images_done;
  end

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int rd       = 0;
  logic [CNT_W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [CNT_W-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd < obs_q.size()) begin
        check_eq(tag, 32'(obs_q[rd]), 32'(e));
        rd++;
      end else begin
        check_eq({tag, "_missing"}, 32'hFFFF_FFFF, 32'(e));
      end
    end
    check_eq({tag, "_extra"}, obs_q.size(), rd);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic request(input logic [CNT_W-1:0] n);
    num_images = n;
    cmd_start  = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i = 0;
    while (!done_intr && i < budget) begin
      tick();
      i++;
    end
    check_eq(tag, done_intr, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      tick();
      i++;
    end
    check_eq(tag, busy, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int s_done, s_dsk, s_svm, s_hi;

  initial begin
    reset = 1'b0; cmd_start = 1'b0; num_images = '0; err_clr = 1'b0;
    tick(3);
    check_eq("rst_dsk_start", dsk_start, 0);
    check_eq("rst_svm_start", svm_start, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done_intr, 0);
    check_eq("rst_error", error_f, 0);
    check_eq("rst_images", images_done, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    reset = 1'b1;
    tick();

    // Batch of three images with alternating deskew/SVM pairs
    s_done = n_done; s_dsk = n_dsk_rise; s_svm = n_svm_rise;
    request(8'd3);
    check_eq("b3_start_next_cycle", dsk_start, 1);
    check_eq("b3_busy", busy, 1);
    cmd_start = 1'b0;
    wait_done("b3_done_seen", 300);
    tick();
    check_eq("b3_busy_after", busy, 0);
    check_eq("b3_images", images_done, 3);
    check_eq("b3_done_pulses", n_done - s_done, 1);
    check_eq("b3_dsk_starts", n_dsk_rise - s_dsk, 3);
    check_eq("b3_svm_starts", n_svm_rise - s_svm, 3);
    check_eq("b3_alternation", n_alt_err, 0);
    exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    sb_check("b3_img_seq");

    // Zero-image batch goes straight to DONE
    s_done = n_done; s_dsk = n_dsk_rise; s_svm = n_svm_rise;
    num_images = 8'd0;
    cmd_start  = 1'b1;
    wait_done("z_done_within_2", 2);
    cmd_start = 1'b0;
    tick(2);
    check_eq("z_images", images_done, 0);
    check_eq("z_done_pulses", n_done - s_done, 1);
    check_eq("z_no_start", (n_dsk_rise - s_dsk) + (n_svm_rise - s_svm), 0);
    exp_q.push_back(8'd0);
    sb_check("z_img_seq");

    // Abort in the third SVM_WAIT, same cycle svm_ready rises
    s_done = n_done; s_dsk = n_dsk_rise; s_svm = n_svm_rise;
    abort_at = svm_fin + 3;
    request(8'd5);
    cmd_start = 1'b0;
    wait_idle("ab_idle", 400);
    abort_at = -1;
    tick(2);
    check_eq("ab_state", dbg_state, ST_IDLE);
    check_eq("ab_images", images_done, 2);
    check_eq("ab_no_intr", n_done - s_done, 0);
    check_eq("ab_svm_starts", n_svm_rise - s_svm, 3);
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    sb_check("ab_img_seq");

    // Command held high across batch end: exactly one batch
    s_done = n_done; s_dsk = n_dsk_rise;
    request(8'd1);
    tick(99);
    check_eq("hold_one_batch", n_done - s_done, 1);
    check_eq("hold_one_dsk", n_dsk_rise - s_dsk, 1);
    check_eq("hold_busy", busy, 0);
    cmd_start = 1'b0;
    tick();
    request(8'd1);
    cmd_start = 1'b0;
    wait_done("hold_second_done", 100);
    tick();
    check_eq("hold_two_batches", n_done - s_done, 2);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    sb_check("hold_img_seq");

    // Timeout: deskew ready stuck high, DSK_START expires after 15 cycles
    dsk_en = 1'b0;
    s_hi = n_dsk_hi;
    request(8'd1);
    cmd_start = 1'b0;
    for (int i = 0; i < 40 && !error_f; i++) tick();
    check_eq("to_error", error_f, 1);
    check_eq("to_dsk_cycles", n_dsk_hi - s_hi, 15);
    check_eq("to_state", dbg_state, ST_ERROR);
    check_eq("to_busy", busy, 0);
    check_eq("to_starts_low", {dsk_start, svm_start}, 0);
    cmd_start = 1'b1;
    tick(3);
    check_eq("to_req_ignored", dbg_state, ST_ERROR);
    check_eq("to_still_error", error_f, 1);
    check_eq("to_no_new_start", n_dsk_hi - s_hi, 15);
    cmd_start = 1'b0;
    err_clr   = 1'b1;
    tick();
    err_clr = 1'b0;
    check_eq("to_clr_error", error_f, 0);
    check_eq("to_clr_state", dbg_state, ST_IDLE);
    dsk_en = 1'b1;
    exp_q.push_back(8'd0);
    sb_check("to_img_seq");

    // Reset during SVM_START
    request(8'd2);
    cmd_start = 1'b0;
    for (int i = 0; i < 50 && !svm_start; i++) tick();
    check_eq("mr_reached_svm", svm_start, 1);
    reset = 1'b0;
    tick();
    check_eq("mr_outputs", {dsk_start, svm_start, busy, done_intr, error_f}, 0);
    check_eq("mr_images", images_done, 0);
    check_eq("mr_state", dbg_state, ST_IDLE);
    reset = 1'b1;
    s_dsk = n_dsk_rise; s_done = n_done;
    tick(20);
    check_eq("mr_no_restart", n_dsk_rise - s_dsk, 0);
    check_eq("mr_no_intr", n_done - s_done, 0);
    request(8'd1);
    cmd_start = 1'b0;
    wait_done("mr_resume_done", 100);
    tick();
    check_eq("mr_resume_images", images_done, 1);
    check_eq("overlap_total", n_overlap, 0);
    exp_q.push_back(8'd1);
    sb_check("mr_img_seq");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
